// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle RV32I control unit. A Moore FSM steps each instruction through
// fetch, decode, execute, memory and writeback, sharing one ALU and one memory
// port. Datapath muxes, register file, PC and IR are external and are steered
// by the outputs below. A memory request/ready handshake is guarded by a
// timeout counter; expiry parks the FSM in FAULT until reset.
//
// Parameters
//   ALUCTRL_W    width of alu_control (default 4)
//   MEM_TIMEOUT  cycles of mem_ready=0 tolerated in one request, 1..255
//
// Optional feature macro
//   ILLEGAL_TRAP_EN  when defined, an unrecognised opcode in DECODE enters
//                    FAULT; otherwise it is treated as a NOP (back to FETCH).
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   opcode/funct3/funct7_5    instruction fields from the external IR
//   zero/less/u_less          ALU flags used by BRANCH
//   mem_ready                 memory completes current request this cycle
//   mem_req/mem_we/adr_src    memory port control
//   ir_write/pc_write/reg_we  architectural state write enables
//   alu_src_a/alu_src_b       ALU operand selects
//   result_src                result bus select
//   alu_control               ALU operation
//   extend_sel                immediate format
//   busy/fault                status
//
// All outputs except ir_write and pc_write are registered: they are decoded
// from the next state and captured together with it, so they always match
// the current state. ir_write and pc_write also depend on mem_ready and the
// branch flags in the same cycle.
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 less,
    input  logic                 u_less,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_we,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [2:0]           extend_sel,
    output logic                 busy,
    output logic                 fault
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC,
        S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_U = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    // ALU operation for R/I arithmetic; only R-type honours funct7_5 for sub.
    function automatic logic [3:0] alu_op_decode(input logic [2:0] f3,
                                                 input logic       f7_5,
                                                 input logic       is_rtype);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_rtype && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Branch condition from funct3 and the ALU flags of rs1 - rs2.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       z,
                                          input logic       lt,
                                          input logic       ult);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = lt;
            3'b101:  t = ~lt;
            3'b110:  t = ult;
            3'b111:  t = ~ult;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  in_mem_s, timeout_s;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  adr_src_q, adr_src_d;
    logic                  reg_we_q, reg_we_d;
    logic [1:0]            alu_src_a_q, alu_src_a_d;
    logic [1:0]            alu_src_b_q, alu_src_b_d;
    logic [1:0]            result_src_q, result_src_d;
    logic [ALUCTRL_W-1:0]  alu_control_q, alu_control_d;
    logic [2:0]            extend_sel_q, extend_sel_d;
    logic                  busy_q, busy_d;
    logic                  fault_q, fault_d;

    // Timeout counter and next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = 8'd0;
        timeout_s = 1'b0;
        in_mem_s  = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);

        // Counter only runs while a request is outstanding; leaving a request
        // state (or completing) clears it, so each request starts from zero.
        if (in_mem_s && !mem_ready) begin
            if ((cnt_q + 8'd1) == TIMEOUT_C) begin
                timeout_s = 1'b1;
                cnt_d     = 8'd0;
            end else begin
                timeout_s = 1'b0;
                cnt_d     = cnt_q + 8'd1;
            end
        end else begin
            timeout_s = 1'b0;
            cnt_d     = 8'd0;
        end

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_B:              state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = S_FAULT;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            // opcode bit 5 separates store (0100011) from load (0000011).
            S_MEMADR: state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode of the next state, captured alongside it.
    always_comb begin
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        adr_src_d     = 1'b0;
        reg_we_d      = 1'b0;
        alu_src_a_d   = 2'b00;
        alu_src_b_d   = 2'b00;
        result_src_d  = 2'b00;
        alu_control_d = ALUCTRL_W'(ALU_ADD);
        extend_sel_d  = EXT_I;
        busy_d        = 1'b1;
        fault_d       = 1'b0;
        case (state_d)
            S_FETCH: begin
                mem_req_d    = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
            end
            // Speculatively form the branch target into ALUOut.
            S_DECODE: begin
                alu_src_a_d  = 2'b01;
                alu_src_b_d  = 2'b01;
                extend_sel_d = EXT_B;
            end
            S_MEMADR: begin
                alu_src_a_d  = 2'b10;
                alu_src_b_d  = 2'b01;
                extend_sel_d = opcode[5] ? EXT_S : EXT_I;
            end
            S_MEMREAD: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
            end
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_we_d     = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                adr_src_d = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_d   = 2'b10;
                alu_control_d = ALUCTRL_W'(alu_op_decode(funct3, funct7_5, 1'b1));
            end
            S_EXECI: begin
                alu_src_a_d   = 2'b10;
                alu_src_b_d   = 2'b01;
                alu_control_d = ALUCTRL_W'(alu_op_decode(funct3, funct7_5, 1'b0));
            end
            S_ALUWB: begin
                reg_we_d = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_d   = 2'b10;
                alu_control_d = ALUCTRL_W'(ALU_SUB);
            end
            // PC takes the jump target from ALUOut while the ALU forms
            // old PC + 4 for the link register.
            S_JAL: begin
                alu_src_a_d  = 2'b01;
                alu_src_b_d  = 2'b10;
                extend_sel_d = EXT_J;
            end
            // rs1 + imm goes straight to the PC; the datapath clears bit 0.
            S_JALR: begin
                alu_src_a_d  = 2'b10;
                alu_src_b_d  = 2'b01;
                result_src_d = 2'b10;
            end
            S_LUI: begin
                alu_src_a_d  = 2'b10;
                alu_src_b_d  = 2'b01;
                extend_sel_d = EXT_U;
            end
            S_AUIPC: begin
                alu_src_a_d  = 2'b01;
                alu_src_b_d  = 2'b01;
                extend_sel_d = EXT_U;
            end
            S_FAULT: begin
                busy_d  = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Write enables that must react to mem_ready / flags in the same cycle.
    always_comb begin
        if (state_q == S_FETCH) begin
            ir_write = mem_ready;
        end else begin
            ir_write = 1'b0;
        end
        case (state_q)
            S_FETCH:       pc_write = mem_ready;
            S_BRANCH:      pc_write = branch_taken(funct3, zero, less, u_less);
            S_JAL, S_JALR: pc_write = 1'b1;
            default:       pc_write = 1'b0;
        endcase
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            adr_src_q     <= 1'b0;
            reg_we_q      <= 1'b0;
            alu_src_a_q   <= 2'b00;
            alu_src_b_q   <= 2'b00;
            result_src_q  <= 2'b00;
            alu_control_q <= '0;
            extend_sel_q  <= 3'b000;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            adr_src_q     <= adr_src_d;
            reg_we_q      <= reg_we_d;
            alu_src_a_q   <= alu_src_a_d;
            alu_src_b_q   <= alu_src_b_d;
            result_src_q  <= result_src_d;
            alu_control_q <= alu_control_d;
            extend_sel_q  <= extend_sel_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign adr_src     = adr_src_q;
    assign reg_we      = reg_we_q;
    assign alu_src_a   = alu_src_a_q;
    assign alu_src_b   = alu_src_b_q;
    assign result_src  = result_src_q;
    assign alu_control = alu_control_q;
    assign extend_sel  = extend_sel_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// Self-checking bench for multicycle_controller (default parameters).
// A table of instruction vectors is run from FETCH back to FETCH; per-vector
// cycle count, write-enable activity and execute-cycle ALU/immediate selects
// are compared to hand-computed values. Hand-written sequences cover reset,
// the illegal opcode, the timeout boundary and the timeout fault.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0, less = 1'b0, u_less = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_we;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_control;
    logic [2:0] extend_sel;
    logic       busy, fault;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .less(less), .u_less(u_less),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control),
        .extend_sel(extend_sel), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z, lt, ult;
        int         dly;        // mem_ready=0 cycles in the data access
        int         exp_cyc;    // FETCH to next FETCH
        int         exp_reg;    // cycles with reg_we=1
        int         exp_mw;     // cycles with mem_we=1
        int         exp_pcw;    // cycles with pc_write=1
        logic [3:0] exp_alu;    // alu_control in third cycle
        logic [2:0] exp_ext;    // extend_sel in third cycle
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {11'd0, mem_req, mem_we, adr_src, ir_write, pc_write, reg_we,
                alu_src_a, alu_src_b, result_src, alu_control, extend_sel,
                busy, fault};
    endfunction

    // Asserts rst immediately (mid-cycle allowed), then releases it and
    // checks IDLE followed by FETCH. Returns 1 time unit into FETCH.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        check({tag, " outputs in reset"}, out_vec(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, " outputs in IDLE"}, out_vec(), 32'd0);
        @(negedge clk);
        #1;
        check({tag, " FETCH mem_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, " FETCH busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Runs one instruction from FETCH until the next FETCH is seen.
    task automatic run_vec(input int idx, input vec_t v);
        int         cyc = 0, n_reg = 0, n_mw = 0, n_pcw = 0, waits = 0, n_bad = 0;
        logic [3:0] alu2 = 4'hF;
        logic [2:0] ext2 = 3'h7;
        bit         done = 1'b0;
        opcode = v.op; funct3 = v.f3; funct7_5 = v.f7;
        zero = v.z; less = v.lt; u_less = v.ult;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (mem_req && adr_src && waits < v.dly) begin
                mem_ready = 1'b0;
                waits++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (k > 0 && mem_req && !adr_src && alu_src_b == 2'b10) begin
                done = 1'b1;
                cyc  = k;
            end else begin
                n_reg += int'(reg_we);
                n_mw  += int'(mem_we);
                n_pcw += int'(pc_write);
                if (k == 2) begin
                    alu2 = alu_control;
                    ext2 = extend_sel;
                end
                if (!busy || fault || (mem_we && !mem_req)) n_bad++;
                @(negedge clk);
            end
        end
        check($sformatf("vec%0d cycles", idx), cyc, v.exp_cyc);
        check($sformatf("vec%0d reg_we cycles", idx), n_reg, v.exp_reg);
        check($sformatf("vec%0d mem_we cycles", idx), n_mw, v.exp_mw);
        check($sformatf("vec%0d pc_write cycles", idx), n_pcw, v.exp_pcw);
        check($sformatf("vec%0d alu_control", idx), {28'd0, alu2}, {28'd0, v.exp_alu});
        check($sformatf("vec%0d extend_sel", idx), {29'd0, ext2}, {29'd0, v.exp_ext});
        check($sformatf("vec%0d bad status cycles", idx), n_bad, 0);
    endtask

    initial begin : main
        int  n;
        bit  found;
        int  n_side;
        //         op          f3      f7    z     lt    ult  dly cyc reg mw pcw alu      ext
        vecs.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0000, 3'b000}); // add
        vecs.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0001, 3'b000}); // sub
        vecs.push_back('{7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0101, 3'b000}); // sll
        vecs.push_back('{7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b1000, 3'b000}); // slt
        vecs.push_back('{7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b1001, 3'b000}); // sltu
        vecs.push_back('{7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0100, 3'b000}); // xor
        vecs.push_back('{7'b0110011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0110, 3'b000}); // srl
        vecs.push_back('{7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0111, 3'b000}); // sra
        vecs.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0011, 3'b000}); // or
        vecs.push_back('{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0010, 3'b000}); // and
        vecs.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0000, 3'b000}); // addi, bit30 set
        vecs.push_back('{7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0111, 3'b000}); // srai
        vecs.push_back('{7'b0010011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b1001, 3'b000}); // sltiu
        vecs.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 1, 0, 1, 4'b0000, 3'b000}); // lw
        vecs.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3, 8, 1, 0, 1, 4'b0000, 3'b000}); // lw, 3 waits
        vecs.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 0, 1, 1, 4'b0000, 3'b001}); // sw
        vecs.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2, 6, 0, 3, 1, 4'b0000, 3'b001}); // sw, 2 waits
        vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 0, 0, 2, 4'b0001, 3'b000}); // beq taken
        vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 0, 0, 1, 4'b0001, 3'b000}); // beq not
        vecs.push_back('{7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 0, 0, 1, 4'b0001, 3'b000}); // bne not
        vecs.push_back('{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 0, 0, 1, 4'b0001, 3'b000}); // bge less=1
        vecs.push_back('{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 0, 0, 2, 4'b0001, 3'b000}); // bge less=0
        vecs.push_back('{7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 0, 0, 2, 4'b0001, 3'b000}); // blt taken
        vecs.push_back('{7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 0, 0, 2, 4'b0001, 3'b000}); // bltu taken
        vecs.push_back('{7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 0, 0, 1, 4'b0001, 3'b000}); // bgeu not
        vecs.push_back('{7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 0, 3, 0, 0, 1, 4'b0001, 3'b000}); // f3=010 never
        vecs.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 2, 4'b0000, 3'b100}); // jal
        vecs.push_back('{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 2, 4'b0000, 3'b000}); // jalr
        vecs.push_back('{7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0000, 3'b011}); // lui
        vecs.push_back('{7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 1, 4'b0000, 3'b011}); // auipc

        do_reset("power-on");

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Unrecognised opcode 0000000.
        do_reset("pre-illegal");
        opcode = 7'b0000000; funct3 = 3'b000; funct7_5 = 1'b0;
        mem_ready = 1'b1;
        n_side = int'(reg_we) + int'(mem_we);
        @(negedge clk); #1;
        check("illegal DECODE alu_src_a", {30'd0, alu_src_a}, 32'd1);
        n_side += int'(reg_we) + int'(mem_we);
        @(negedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
        check("illegal fault", {31'd0, fault}, 32'd1);
        check("illegal busy", {31'd0, busy}, 32'd0);
        check("illegal mem_req", {31'd0, mem_req}, 32'd0);
`else
        check("nop back in FETCH mem_req", {31'd0, mem_req}, 32'd1);
        check("nop back in FETCH adr_src", {31'd0, adr_src}, 32'd0);
        check("nop fault", {31'd0, fault}, 32'd0);
`endif
        n_side += int'(reg_we) + int'(mem_we);
        check("illegal no reg/mem write", n_side, 0);

        // mem_ready arriving on the last allowed FETCH cycle completes.
        do_reset("pre-boundary");
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
        mem_ready = 1'b0;
        repeat (15) begin
            @(negedge clk); #1;
        end
        check("boundary still FETCH", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        #1;
        check("boundary ir_write", {31'd0, ir_write}, 32'd1);
        check("boundary pc_write", {31'd0, pc_write}, 32'd1);
        @(negedge clk); #1;
        check("boundary no fault", {31'd0, fault}, 32'd0);
        check("DECODE alu_src_a", {30'd0, alu_src_a}, 32'd1);
        check("DECODE alu_src_b", {30'd0, alu_src_b}, 32'd1);
        check("DECODE extend_sel", {29'd0, extend_sel}, 32'd2);
        check("DECODE mem_req", {31'd0, mem_req}, 32'd0);

        // Reset in the middle of a load's MEMREAD.
        do_reset("pre-memread");
        opcode = 7'b0000011; funct3 = 3'b010;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            mem_ready = (mem_req && adr_src) ? 1'b0 : 1'b1;
            #1;
            if (mem_req && adr_src && !mem_we) begin
                found = 1'b1;
            end else begin
                @(negedge clk); #1;
            end
        end
        check("reached MEMREAD", {31'd0, found}, 32'd1);
        do_reset("mid-memread");

        // Fetch that never completes: fault after MEM_TIMEOUT cycles.
        opcode = 7'b0110011;
        mem_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !fault; k++) begin
            if (mem_req) n++;
            @(negedge clk); #1;
        end
        check("timeout FETCH cycles", n, 16);
        check("timeout fault", {31'd0, fault}, 32'd1);
        check("timeout busy", {31'd0, busy}, 32'd0);
        check("timeout mem_req", {31'd0, mem_req}, 32'd0);
        mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("fault sticky outputs", out_vec(), 32'd1);
        do_reset("after fault");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
